// File: rtl/sr_cmd_sequencer_if.sv
// Signal bundle between the command sequencer and its environment: the raw
// set/clear requests and flip-flop feedback in, the S/R drive and status out.
interface sr_cmd_sequencer_if;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic S;
    logic R;
    logic busy;
    logic exp_q;
    logic err;

    // Environment side: issues requests, returns Q, observes drive and status.
    modport master (
        output set_req, clr_req, q_fb,
        input  S, R, busy, exp_q, err
    );

    // Sequencer side.
    modport slave (
        input  set_req, clr_req, q_fb,
        output S, R, busy, exp_q, err
    );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Command front-end for an SR flip-flop. Raw set/clear requests are
// synchronised and debounced, and each debounced rising edge becomes an event.
// Events are turned into fixed-width S or R pulses that never overlap. After
// each pulse there is a hold-off period, at the end of which the flip-flop's Q
// is compared against the expected state. A sticky error flag records any
// disagreement.
module sr_cmd_sequencer #(
    parameter int DB_CYCLES      = 4,
    parameter int PULSE_CYCLES   = 2,
    parameter int HOLDOFF_CYCLES = 3,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, HOLD} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_SET, REQ_CLR} req_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    // Bit 0 carries the set request and bit 1 carries the clear request.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [1:0]       db_d;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       ev;

    assign raw = {bus.clr_req, bus.set_req};

    // Two-flop synchronizer followed by a debouncer, one per request.
    // NOTE: every register, including the small debounce counter array, is
    // cleared by the async reset so that no stale event survives rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments here make sync2 take the old
            // sync1, so the two flops really form a two-stage chain.
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // An event is a one-cycle pulse on the rising edge of the debounced level.
    assign ev = db & ~db_d;

    state_t           state, state_nx;
    req_t             pend, pend_nx;
    req_t             req_now, take;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             s_q, s_nx;
    logic             r_q, r_nx;
    logic             exp_q_q, exp_nx;
    logic             err_q, err_nx;

    // FSM state, the pulse/hold counter, the registered drive and the pending
    // request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= REQ_NONE;
            cnt     <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            exp_q_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            cnt     <= cnt_nx;
            s_q     <= s_nx;
            r_q     <= r_nx;
            exp_q_q <= exp_nx;
            err_q   <= err_nx;
        end
    end

    // Next state logic: event qualification, pulse and hold timing, Q check
    // and pending capture.
    always_comb begin
        // NOTE: every signal gets a default value before the case statement,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_nx = state;
        pend_nx  = pend;
        cnt_nx   = cnt;
        s_nx     = s_q;
        r_nx     = r_q;
        exp_nx   = exp_q_q;
        err_nx   = err_q;
        take     = REQ_NONE;

        // When both events fire in the same cycle, clear wins.
        if (ev[1])      req_now = REQ_CLR;
        else if (ev[0]) req_now = REQ_SET;
        else            req_now = REQ_NONE;

        case (state)
            IDLE: begin
                // A fresh event is newer than the pending one. Either way,
                // the pending entry is consumed here.
                take    = (req_now != REQ_NONE) ? req_now : pend;
                pend_nx = REQ_NONE;
                if (take == REQ_CLR && exp_q_q) begin
                    state_nx = CLR_P;
                    r_nx     = 1'b1;
                    cnt_nx   = '0;
                end else if (take == REQ_SET && !exp_q_q) begin
                    state_nx = SET_P;
                    s_nx     = 1'b1;
                    cnt_nx   = '0;
                end
            end
            SET_P: begin
                if (cnt == PULSE_LAST) begin
                    s_nx     = 1'b0;
                    exp_nx   = 1'b1;
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CLR_P: begin
                if (cnt == PULSE_LAST) begin
                    r_nx     = 1'b0;
                    exp_nx   = 1'b0;
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    if (bus.q_fb != exp_q_q) err_nx = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // While busy, the newest event overwrites the single pending slot.
        if (state != IDLE && req_now != REQ_NONE) pend_nx = req_now;
    end

    assign bus.S     = s_q;
    assign bus.R     = r_q;
    assign bus.busy  = (state != IDLE);
    assign bus.exp_q = exp_q_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed-vector bench for sr_cmd_sequencer. Stimulus pushes hand-computed
// expected transactions into a scoreboard. A monitor watches each busy period
// and compares it with the oldest expected entry.
module tb_sr_cmd_sequencer;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic ff_q;
    logic force_q0;

    sr_cmd_sequencer_if bus ();

    sr_cmd_sequencer #(
        .DB_CYCLES      (4),
        .PULSE_CYCLES   (2),
        .HOLDOFF_CYCLES (3),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One observed or expected busy period.
    typedef struct {
        int   rise;      // cycle number at which S or R first reads high
        int   s_w;       // cycles with S high
        int   r_w;       // cycles with R high
        int   busy_len;  // cycles with busy high
        logic eq;        // exp_q once busy drops
        logic er;        // err once busy drops
    } txn_t;

    txn_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SR flip-flop downstream of the sequencer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ff_q <= 1'b0;
        else if (bus.S) ff_q <= 1'b1;
        else if (bus.R) ff_q <= 1'b0;
    end
    assign bus.q_fb = force_q0 ? 1'b0 : ff_q;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int rise, input int s_w, input int r_w,
                        input int busy_len, input logic eq, input logic er);
        txn_t t;
        t.rise = rise; t.s_w = s_w; t.r_w = r_w;
        t.busy_len = busy_len; t.eq = eq; t.er = er;
        sb_q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: collects one transaction per busy period and scores it.
    initial begin : monitor
        bit   in_txn;
        bit   overlap;
        int   b_len, s_w, r_w, rise;
        txn_t e;
        in_txn = 0;
        overlap = 0;
        b_len = 0; s_w = 0; r_w = 0; rise = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 0;
                continue;
            end
            if (bus.busy) begin
                if (!in_txn) begin
                    in_txn = 1; b_len = 0; s_w = 0; r_w = 0; rise = -1; overlap = 0;
                end
                b_len++;
                if (bus.S) s_w++;
                if (bus.R) r_w++;
                if (bus.S && bus.R) overlap = 1;
                if ((bus.S || bus.R) && rise < 0) rise = cyc;
            end else begin
                if (bus.S || bus.R) check("stray_drive_while_idle", 1, 0);
                if (in_txn) begin
                    in_txn = 0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_txn", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rise_cycle", rise, e.rise);
                        check("s_width", s_w, e.s_w);
                        check("r_width", r_w, e.r_w);
                        check("busy_len", b_len, e.busy_len);
                        check("s_and_r_overlap", int'(overlap), 0);
                        check("exp_q_after", int'(bus.exp_q), int'(e.eq));
                        check("err_after", int'(bus.err), int'(e.er));
                    end
                end
            end
        end
    end

    // Drives a request and pushes the expected set/clear transaction. The
    // request is asserted at the negedge whose cycle count is n; with the
    // default parameters the drive rises at cycle n+7.
    task automatic single(input logic s, input logic c, input logic eq, input logic er);
        int n;
        @(negedge clk);
        n = cyc;
        bus.set_req = s;
        bus.clr_req = c;
        push(n + 7, s && !c ? 2 : 0, c ? 2 : 0, 5, eq, er);
        idle(12);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        idle(12);
    endtask

    initial begin : stimulus
        int n;
        cyc = 0; checks = 0; errors = 0;
        force_q0 = 1'b0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset values must appear without any clock edge.
        check("reset_S", int'(bus.S), 0);
        check("reset_R", int'(bus.R), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_exp_q", int'(bus.exp_q), 0);
        check("reset_err", int'(bus.err), 0);
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // A set request that bounces for only three cycles produces no pulse.
        @(negedge clk);
        bus.set_req = 1'b1;
        idle(3);
        bus.set_req = 1'b0;
        idle(15);
        check("bounce_exp_q", int'(bus.exp_q), 0);
        check("bounce_busy", int'(bus.busy), 0);

        // A clean set: S is high for 2 cycles, busy lasts 5, exp_q becomes 1.
        single(1'b1, 1'b0, 1'b1, 1'b0);

        // With exp_q=1, set and clear rise together: clear wins and R pulses.
        single(1'b1, 1'b1, 1'b0, 1'b0);

        // A clear arrives during SET_P: it waits through HOLD and one IDLE
        // cycle, then R pulses.
        @(negedge clk);
        n = cyc;
        bus.set_req = 1'b1;
        push(n + 7, 2, 0, 5, 1'b1, 1'b0);
        idle(2);
        bus.clr_req = 1'b1;
        push(n + 13, 0, 2, 5, 1'b0, 1'b0);
        idle(12);
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        idle(20);

        // Q is stuck at 0 during a set, so err latches and stays set.
        force_q0 = 1'b1;
        single(1'b1, 1'b0, 1'b1, 1'b1);
        force_q0 = 1'b0;
        single(1'b0, 1'b1, 1'b0, 1'b1);
        single(1'b1, 1'b0, 1'b1, 1'b1);
        single(1'b0, 1'b1, 1'b0, 1'b1);

        idle(10);
        check("scoreboard_drained", sb_q.size(), 0);

        // Reset during the first cycle of an S pulse, with a clear on the way.
        @(negedge clk);
        n = cyc;
        bus.set_req = 1'b1;
        idle(1);
        bus.clr_req = 1'b1;
        idle(6);
        #1 check("s_high_before_reset", int'(bus.S), 1);
        #1 rst_n = 1'b0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        #1;
        check("midpulse_reset_S", int'(bus.S), 0);
        check("midpulse_reset_R", int'(bus.R), 0);
        check("midpulse_reset_busy", int'(bus.busy), 0);
        check("midpulse_reset_exp_q", int'(bus.exp_q), 0);
        check("midpulse_reset_err", int'(bus.err), 0);
        idle(2);
        rst_n = 1'b1;
        idle(20);
        check("post_reset_busy", int'(bus.busy), 0);
        check("post_reset_exp_q", int'(bus.exp_q), 0);
        check("post_reset_scoreboard", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
